// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-ported memory between an instruction-fetch
// port (if_*) and a data port (dm_*).
//
// Each transaction is IDLE -> ACCESS (WAIT_CYCLES cycles with mem_cs high)
// -> ACK (a one-cycle ack to the owner) -> IDLE.
//
// Ports
//   clk, rst                           clock; asynchronous active-high reset
//   if_req/if_addr -> if_rdata/if_ack  fetch port; fetches are always word reads
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata -> dm_rdata/dm_ack
//                                      data port (load or byte-enabled store)
//   mem_cs/we/be/addr/wdata, mem_rdata memory side; driven only from latched regs
//   grant                              one-hot owner: bit0 = fetch, bit1 = data
//   busy                               high in ACCESS and ACK
//
// Build option
//   MEM_ARB_RR_EN  When defined, simultaneous requests alternate between the
//                  two ports. When undefined, data always wins ties.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        pick_dm;

`ifdef MEM_ARB_RR_EN
  // last_dm_q: 1 when data was the most recent winner. It resets to fetch,
  // so the first tie goes to data.
  logic last_dm_q, last_dm_d;
  assign pick_dm   = dm_req && (!if_req || !last_dm_q);
  assign last_dm_d = (state_q == IDLE && (if_req || dm_req)) ? pick_dm : last_dm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_dm_q <= 1'b0;
    else     last_dm_q <= last_dm_d;
  end
`else
  assign pick_dm = dm_req;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d = ACCESS;
          cnt_d   = CNT_LOAD;
          if (pick_dm) begin
            grant_d = 2'b10;
            we_d    = dm_we;
            be_d    = dm_be;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
          end else begin
            // A fetch has no write data, so mem_wdata keeps its last value.
            grant_d = 2'b01;
            we_d    = 1'b0;
            be_d    = 4'b1111;
            addr_d  = if_addr;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          // Read data is captured only on the final ACCESS cycle.
          if (!we_q) begin
            if (grant_q[0]) if_rdata_d = mem_rdata;
            if (grant_q[1]) dm_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      grant_q    <= 2'b00;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_cs    = (state_q == ACCESS);
  assign mem_we    = mem_cs & we_q;
  assign mem_be    = mem_cs ? be_q : 4'b0000;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = (state_q == ACK) & grant_q[0];
  assign dm_ack    = (state_q == ACK) & grant_q[1];
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);

endmodule
